// File: rtl/rs_ldst_queue_pkg.sv
// rs_ldst_queue_pkg: shared widths and defaults for the load/store
// reservation queue and its wakeup matcher.
package rs_ldst_queue_pkg;

    // Core-wide datapath and rename widths.
    localparam int RV32_DATA_WIDTH = 32;
    localparam int RRF_ENT_SEL     = 6;

    // Queue defaults: entry count and number of execute-finish channels.
    localparam int RS_LDST_ENT_NUM = 8;
    localparam int RS_LDST_FWD_NUM = 4;

    // Number of set bits in a two-slot dispatch mask.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/rs_ldst_queue_if.sv
// rs_ldst_queue_if: dispatch, broadcast and issue signals of the load/store
// reservation queue. The master side is the dispatcher/execute/LSU
// environment, the slave side is the queue itself.
interface rs_ldst_queue_if
    import rs_ldst_queue_pkg::*;
#(
    parameter int DATA_W  = RV32_DATA_WIDTH,
    parameter int TAG_W   = RRF_ENT_SEL,
    parameter int NUM_FWD = RS_LDST_FWD_NUM,
    parameter int DEPTH   = RS_LDST_ENT_NUM
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                      i_flush;
    logic [1:0]                i_dp_en;
    logic [1:0]                i_dp_rs1_vld;
    logic [1:0]                i_dp_rs2_vld;
    logic [2*DATA_W-1:0]       i_dp_rs1;
    logic [2*DATA_W-1:0]       i_dp_rs2;
    logic [2*DATA_W-1:0]       i_dp_imm;
    logic [1:0]                i_dp_is_st;
    logic [2*TAG_W-1:0]        i_dp_rrftag;
    logic [CNT_W-1:0]          o_free_cnt;
    logic                      o_err;
    logic [NUM_FWD-1:0]        i_fwd_vld;
    logic [NUM_FWD*TAG_W-1:0]  i_fwd_tag;
    logic [NUM_FWD*DATA_W-1:0] i_fwd_data;
    logic                      o_issue_vld;
    logic                      i_issue_rdy;
    logic [DATA_W-1:0]         o_issue_rs1;
    logic [DATA_W-1:0]         o_issue_rs2;
    logic [DATA_W-1:0]         o_issue_imm;
    logic                      o_issue_is_st;
    logic [TAG_W-1:0]          o_issue_rrftag;

    modport master (
        output i_flush, i_dp_en, i_dp_rs1_vld, i_dp_rs2_vld, i_dp_rs1, i_dp_rs2,
               i_dp_imm, i_dp_is_st, i_dp_rrftag, i_fwd_vld, i_fwd_tag,
               i_fwd_data, i_issue_rdy,
        input  o_free_cnt, o_err, o_issue_vld, o_issue_rs1, o_issue_rs2,
               o_issue_imm, o_issue_is_st, o_issue_rrftag
    );

    modport slave (
        input  i_flush, i_dp_en, i_dp_rs1_vld, i_dp_rs2_vld, i_dp_rs1, i_dp_rs2,
               i_dp_imm, i_dp_is_st, i_dp_rrftag, i_fwd_vld, i_fwd_tag,
               i_fwd_data, i_issue_rdy,
        output o_free_cnt, o_err, o_issue_vld, o_issue_rs1, o_issue_rs2,
               o_issue_imm, o_issue_is_st, o_issue_rrftag
    );

endinterface

// File: rtl/rs_ldst_wakeup.sv
// rs_ldst_wakeup: compares one waiting operand tag against every valid
// execute-finish broadcast; the lowest-numbered matching channel supplies data.
module rs_ldst_wakeup
    import rs_ldst_queue_pkg::*;
#(
    parameter int DATA_W  = RV32_DATA_WIDTH,
    parameter int TAG_W   = RRF_ENT_SEL,
    parameter int NUM_FWD = RS_LDST_FWD_NUM
) (
    input  logic [TAG_W-1:0]          tag,
    input  logic [NUM_FWD-1:0]        fwd_vld,
    input  logic [NUM_FWD*TAG_W-1:0]  fwd_tag,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic                      match,
    output logic [DATA_W-1:0]         data
);

    // Scan from the highest channel down so the lowest matching index wins.
    always_comb begin
        match = 1'b0;
        data  = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_vld[i] && (fwd_tag[i*TAG_W +: TAG_W] == tag)) begin
                match = 1'b1;
                data  = fwd_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/rs_ldst_queue.sv
// rs_ldst_queue: in-order load/store reservation queue. Up to two ops are
// dispatched per cycle into a circular buffer, waiting operands are woken by
// the execute-finish broadcasts, and the head entry issues to the LSU.
// Optional feature macro: RS_LDST_ISSUE_BYPASS_EN lets the head see
// same-cycle broadcasts so it can issue in the broadcast cycle.
module rs_ldst_queue
    import rs_ldst_queue_pkg::*;
#(
    parameter int DEPTH   = RS_LDST_ENT_NUM,
    parameter int DATA_W  = RV32_DATA_WIDTH,
    parameter int TAG_W   = RRF_ENT_SEL,
    parameter int NUM_FWD = RS_LDST_FWD_NUM
) (
    input logic            clk,
    input logic            rst_n,
    rs_ldst_queue_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0]  head;
    logic [CNT_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              err;

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  rs1_vld;
    logic [DEPTH-1:0]  rs2_vld;
    logic [DEPTH-1:0]  is_st;
    logic [DATA_W-1:0] rs1    [DEPTH];
    logic [DATA_W-1:0] rs2    [DEPTH];
    logic [DATA_W-1:0] imm    [DEPTH];
    logic [TAG_W-1:0]  rrftag [DEPTH];

    logic [CNT_W-1:0]  free_cnt;
    logic              acc0;
    logic              acc1;
    logic [1:0]        acc_num;
    logic              overflow;

    logic [1:0]        dp_rs1_rdy;
    logic [1:0]        dp_rs2_rdy;
    logic [DATA_W-1:0] dp_rs1 [2];
    logic [DATA_W-1:0] dp_rs2 [2];
    logic [DATA_W-1:0] dp_imm [2];
    logic [TAG_W-1:0]  dp_tag [2];

    logic [1:0]        wr_en;
    logic              sel0;
    logic [IDX_W-1:0]  wr_idx     [2];
    logic [1:0]        wr_rs1_vld;
    logic [1:0]        wr_rs2_vld;
    logic [1:0]        wr_is_st;
    logic [DATA_W-1:0] wr_rs1     [2];
    logic [DATA_W-1:0] wr_rs2     [2];
    logic [DATA_W-1:0] wr_imm     [2];
    logic [TAG_W-1:0]  wr_tag     [2];

    logic [DEPTH-1:0]  ent_rs1_match;
    logic [DEPTH-1:0]  ent_rs2_match;
    logic [DATA_W-1:0] ent_rs1_data [DEPTH];
    logic [DATA_W-1:0] ent_rs2_data [DEPTH];

    logic [IDX_W-1:0]  head_idx;
    logic              head_rs1_rdy;
    logic              head_rs2_rdy;
    logic [DATA_W-1:0] head_rs1;
    logic [DATA_W-1:0] head_rs2;
    logic              issue_vld;
    logic              fire;

    assign free_cnt = CNT_W'(DEPTH) - count;
    assign head_idx = head[IDX_W-1:0];

    // Dispatch operands: a not-ready operand whose producer broadcasts in the
    // dispatch cycle is captured immediately so it cannot miss its wakeup.
    for (genvar s = 0; s < 2; s++) begin : g_dp
        logic              m1;
        logic              m2;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;

        rs_ldst_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_FWD(NUM_FWD)) u_wk_rs1 (
            .tag      (bus.i_dp_rs1[s*DATA_W +: TAG_W]),
            .fwd_vld  (bus.i_fwd_vld),
            .fwd_tag  (bus.i_fwd_tag),
            .fwd_data (bus.i_fwd_data),
            .match    (m1),
            .data     (d1)
        );

        rs_ldst_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_FWD(NUM_FWD)) u_wk_rs2 (
            .tag      (bus.i_dp_rs2[s*DATA_W +: TAG_W]),
            .fwd_vld  (bus.i_fwd_vld),
            .fwd_tag  (bus.i_fwd_tag),
            .fwd_data (bus.i_fwd_data),
            .match    (m2),
            .data     (d2)
        );

        assign dp_rs1_rdy[s] = bus.i_dp_rs1_vld[s] | m1;
        assign dp_rs2_rdy[s] = bus.i_dp_rs2_vld[s] | m2;
        assign dp_rs1[s] = (!bus.i_dp_rs1_vld[s] && m1) ? d1 : bus.i_dp_rs1[s*DATA_W +: DATA_W];
        assign dp_rs2[s] = (!bus.i_dp_rs2_vld[s] && m2) ? d2 : bus.i_dp_rs2[s*DATA_W +: DATA_W];
        assign dp_imm[s] = bus.i_dp_imm[s*DATA_W +: DATA_W];
        assign dp_tag[s] = bus.i_dp_rrftag[s*TAG_W +: TAG_W];
    end

    // Stored operands: each busy entry keeps listening for its producer tags.
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        rs_ldst_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_FWD(NUM_FWD)) u_wk_rs1 (
            .tag      (rs1[e][TAG_W-1:0]),
            .fwd_vld  (bus.i_fwd_vld),
            .fwd_tag  (bus.i_fwd_tag),
            .fwd_data (bus.i_fwd_data),
            .match    (ent_rs1_match[e]),
            .data     (ent_rs1_data[e])
        );

        rs_ldst_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_FWD(NUM_FWD)) u_wk_rs2 (
            .tag      (rs2[e][TAG_W-1:0]),
            .fwd_vld  (bus.i_fwd_vld),
            .fwd_tag  (bus.i_fwd_tag),
            .fwd_data (bus.i_fwd_data),
            .match    (ent_rs2_match[e]),
            .data     (ent_rs2_data[e])
        );
    end

    // Admission against the registered free count; slot 1 is dropped first.
    always_comb begin
        acc0     = bus.i_dp_en[0] && (free_cnt != '0);
        acc1     = bus.i_dp_en[1] && (free_cnt >= (bus.i_dp_en[0] ? CNT_W'(2) : CNT_W'(1)));
        acc_num  = popcount2({acc1, acc0});
        overflow = (popcount2(bus.i_dp_en) != acc_num);
    end

    // Two write ports: port 0 at tail takes the oldest accepted slot,
    // port 1 at tail+1 only ever carries slot 1.
    always_comb begin
        wr_en         = {acc0 & acc1, acc0 | acc1};
        sel0          = !acc0;
        wr_idx[0]     = tail[IDX_W-1:0];
        wr_idx[1]     = tail[IDX_W-1:0] + IDX_W'(1);
        wr_rs1_vld[0] = dp_rs1_rdy[sel0];
        wr_rs2_vld[0] = dp_rs2_rdy[sel0];
        wr_is_st[0]   = bus.i_dp_is_st[sel0];
        wr_rs1[0]     = dp_rs1[sel0];
        wr_rs2[0]     = dp_rs2[sel0];
        wr_imm[0]     = dp_imm[sel0];
        wr_tag[0]     = dp_tag[sel0];
        wr_rs1_vld[1] = dp_rs1_rdy[1];
        wr_rs2_vld[1] = dp_rs2_rdy[1];
        wr_is_st[1]   = bus.i_dp_is_st[1];
        wr_rs1[1]     = dp_rs1[1];
        wr_rs2[1]     = dp_rs2[1];
        wr_imm[1]     = dp_imm[1];
        wr_tag[1]     = dp_tag[1];
    end

    // Head issue view; with the bypass the head also sees this cycle's broadcasts.
    always_comb begin
        head_rs1_rdy = rs1_vld[head_idx];
        head_rs2_rdy = rs2_vld[head_idx];
        head_rs1     = rs1[head_idx];
        head_rs2     = rs2[head_idx];
`ifdef RS_LDST_ISSUE_BYPASS_EN
        if (!rs1_vld[head_idx] && ent_rs1_match[head_idx]) begin
            head_rs1_rdy = 1'b1;
            head_rs1     = ent_rs1_data[head_idx];
        end
        if (!rs2_vld[head_idx] && ent_rs2_match[head_idx]) begin
            head_rs2_rdy = 1'b1;
            head_rs2     = ent_rs2_data[head_idx];
        end
`endif
        issue_vld = busy[head_idx] && head_rs1_rdy && head_rs2_rdy;
        fire      = issue_vld && bus.i_issue_rdy;
    end

    assign bus.o_issue_vld    = issue_vld;
    assign bus.o_issue_rs1    = issue_vld ? head_rs1 : '0;
    assign bus.o_issue_rs2    = issue_vld ? head_rs2 : '0;
    assign bus.o_issue_imm    = issue_vld ? imm[head_idx] : '0;
    assign bus.o_issue_is_st  = issue_vld ? is_st[head_idx] : 1'b0;
    assign bus.o_issue_rrftag = issue_vld ? rrftag[head_idx] : '0;
    assign bus.o_free_cnt     = free_cnt;
    assign bus.o_err          = err;

    // Pointers, occupancy and the sticky overflow flag; flush wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (bus.i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + CNT_W'(fire);
            tail  <= tail + CNT_W'(acc_num);
            count <= count + CNT_W'(acc_num) - CNT_W'(fire);
            if (overflow) begin
                err <= 1'b1;
            end
        end
    end

    // Entry storage: wakeup capture, head retirement and dispatch writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            rs1_vld <= '0;
            rs2_vld <= '0;
            is_st   <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                rs1[e]    <= '0;
                rs2[e]    <= '0;
                imm[e]    <= '0;
                rrftag[e] <= '0;
            end
        end else if (bus.i_flush) begin
            busy <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (busy[e] && !rs1_vld[e] && ent_rs1_match[e]) begin
                    rs1_vld[e] <= 1'b1;
                    rs1[e]     <= ent_rs1_data[e];
                end
                if (busy[e] && !rs2_vld[e] && ent_rs2_match[e]) begin
                    rs2_vld[e] <= 1'b1;
                    rs2[e]     <= ent_rs2_data[e];
                end
                if (fire && (IDX_W'(e) == head_idx)) begin
                    busy[e] <= 1'b0;
                end
                for (int p = 0; p < 2; p++) begin
                    if (wr_en[p] && (IDX_W'(e) == wr_idx[p])) begin
                        busy[e]    <= 1'b1;
                        rs1_vld[e] <= wr_rs1_vld[p];
                        rs2_vld[e] <= wr_rs2_vld[p];
                        is_st[e]   <= wr_is_st[p];
                        rs1[e]     <= wr_rs1[p];
                        rs2[e]     <= wr_rs2[p];
                        imm[e]     <= wr_imm[p];
                        rrftag[e]  <= wr_tag[p];
                    end
                end
            end
        end
    end

endmodule
